lane_spawner: RTL and testbench
===============================

Name: lane_spawner

Overview:
- Parametrised pseudo-random spawner for the road/obstacle playfield.
- Owns a free-running LFSR and picks a new road segment lane on each road tick.
- Runs a scan FSM that finds a free lane for the next obstacle and offers it on a valid/ready handshake.
- Keeps a per-lane speed register for the sprite movers.

Parameters:
- NUM_LANES, 5, lane count; must be >= 2.
- SPEED_W, 2, width of each lane speed value; SMAX = 2**SPEED_W - 1.
- LFSR_W, 16, LFSR width; must be >= 8.
- LFSR_TAPS, 16'hB400, Galois feedback mask.
- SEED, 16'hACE1, LFSR reset value; a SEED of 0 is replaced by 1.
- SPAWN_GAP, 64, cycles between spawn attempts; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  spawning allowed
- direction  in  4  player steering; nonzero adds an extra LFSR step
- road_tick  in  1  one-cycle request for a new road segment
- road_on  in  NUM_LANES  lane already has a road segment
- car_on  in  NUM_LANES  lane occupied by a car or obstacle
- path  out  NUM_LANES  one-hot lane of the latest road segment
- path_valid  out  1  one-cycle pulse when path updates
- obs_valid  out  1  obstacle offer valid
- obs_ready  in  1  consumer accepts the offer
- obs_lane  out  $clog2(NUM_LANES)  offered lane index
- obs_speed  out  SPEED_W  offered speed
- speed_data  out  NUM_LANES*SPEED_W  packed per-lane speed; lane i occupies bits [i*SPEED_W +: SPEED_W]
- spawn_fail  out  1  one-cycle pulse when a scan finds no free lane

Behaviour:
- Reset (async, rst_n=0):
  - LFSR = SEED, or 1 if SEED = 0.
  - State IDLE, cooldown = SPAWN_GAP-1.
  - path = 0, path_valid = 0, obs_valid = 0, obs_lane = 0, obs_speed = 0, speed_data = 0, spawn_fail = 0.
- Reset mid-offer drops the offer immediately.
- LFSR:
  - Advances one Galois step per cycle, two steps when direction != 0.
  - Never reaches 0.
  - rnd_a = lfsr[7:0] % NUM_LANES; rnd_b = lfsr[LFSR_W-1 -: 8] % NUM_LANES. Both come from the current, pre-advance value.
- Road path:
  - On road_tick with road_on[rnd_b] = 0: path <= one-hot(rnd_b), path_valid = 1 the next cycle.
  - On road_tick with road_on[rnd_b] = 1: path holds, no pulse.
  - Independent of enable.
- Lane speed: base(i) = 1 + (i*(SMAX-1) + (NUM_LANES-1)/2) / (NUM_LANES-1), integer arithmetic. For the defaults this gives 1,2,2,3,3.
- FSM state IDLE:
  - enable=1: cooldown decrements each cycle.
  - enable=0: cooldown freezes.
  - cooldown = 0 and enable=1 -> SCAN; latch idx = rnd_a, tries = 0.
- FSM state SCAN (one lane per cycle):
  - car_on[idx] = 0 -> OFFER; obs_lane = idx, obs_speed = base(idx).
  - Otherwise idx = (idx+1) wraps at NUM_LANES, tries++.
  - tries = NUM_LANES-1 and the lane is still busy -> spawn_fail pulse, reload cooldown, go IDLE.
  - enable=0 -> abort to IDLE; cooldown reload, no fail pulse.
  - Worst case: NUM_LANES cycles.
- FSM state OFFER:
  - obs_valid = 1; obs_lane and obs_speed stay stable until the handshake, regardless of car_on or enable.
  - obs_valid & obs_ready -> speed_data[obs_lane] <= obs_speed, reload cooldown, IDLE.
  - obs_valid drops the cycle after the handshake.
- Minimum spawn period is SPAWN_GAP + 2 cycles. When ready is held high:
  - SPAWN_GAP cycles IDLE, then SCAN then OFFER, then IDLE.
  - A lane found on the first scan cycle gives obs_valid 1 cycle after SCAN entry.
- Ready asserted while not valid is ignored.
- Lanes other than the accepted one keep their speed_data.

Optional Feature:
- Macro: LANE_SPAWNER_STATS_EN.
- Defined: adds outputs spawn_cnt[15:0] and fail_cnt[15:0].
  - spawn_cnt increments on each handshake; fail_cnt increments on each spawn_fail.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package spawner_pkg holds:
  - the FSM state enum (IDLE, SCAN, OFFER);
  - the default LFSR_TAPS/SEED constants;
  - the function lane_base_speed(lane, num_lanes, smax).
- One sub-module, galois_lfsr (LFSR_W, LFSR_TAPS, SEED; inputs step2, outputs state), shared with other random sources.

Test Plan:
- Reset with SEED=0 -> LFSR=1, all outputs 0, state IDLE; release, car_on=0, obs_ready=1 -> first obs_valid at cycle SPAWN_GAP+1 after reset release.
- car_on=5'b11011 with a forced start at lane 0 -> lanes 0,1 scanned busy, obs_lane=2, obs_speed=2; after handshake speed_data lane 2 = 2, others 0.
- car_on=5'b11111 -> spawn_fail pulses once after 5 SCAN cycles, no obs_valid, cooldown restarts at SPAWN_GAP-1.
- obs_ready=0 for 10 cycles while car_on toggles -> obs_valid, obs_lane, obs_speed stable; ready=1 -> single accept, valid low next cycle.
- road_tick with road_on[rnd_b]=1 -> no path_valid, path unchanged; road_on=0 -> path = one-hot(rnd_b), one-cycle path_valid.
- direction=4'b0010 held for 4 cycles -> LFSR matches a reference model advanced 8 steps; rst_n low mid-OFFER -> obs_valid drops without waiting for clk.

Source files
------------

// File: rtl/spawner_pkg.sv
// Shared FSM state type, default LFSR constants and lane speed helper for the spawner family.
package spawner_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      OFFER = 2'd2
   } spawn_state_t;

   localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
   localparam logic [15:0] DEF_SEED      = 16'hACE1;

   // Spreads speeds 1..smax evenly across the lanes, rounding to nearest.
   function automatic int lane_base_speed(input int lane, input int num_lanes, input int smax);
      return 1 + (lane * (smax - 1) + (num_lanes - 1) / 2) / (num_lanes - 1);
   endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Galois LFSR advancing one step per cycle, two when step2 is high; a zero seed is replaced by 1.
module galois_lfsr
   import spawner_pkg::*;
#(
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
   parameter logic [LFSR_W-1:0] SEED      = DEF_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step2,
   output logic [LFSR_W-1:0] state
);

   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

   // Tap mask has its MSB set, so a nonzero state can never shift into zero.
   function automatic logic [LFSR_W-1:0] adv(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED_EFF;
      end else begin
         state <= step2 ? adv(adv(state)) : adv(state);
      end
   end

endmodule

// File: rtl/lane_spawner.sv
// Road path picker plus obstacle scan/offer FSM; offer held on valid/ready until accepted, one attempt per SPAWN_GAP+2 cycles minimum.
// Define LANE_SPAWNER_STATS_EN to add saturating spawn_cnt/fail_cnt outputs.
module lane_spawner
   import spawner_pkg::*;
#(
   parameter int                NUM_LANES = 5,
   parameter int                SPEED_W   = 2,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
   parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
   parameter int                SPAWN_GAP = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic [3:0]                     direction,
   input  logic                           road_tick,
   input  logic [NUM_LANES-1:0]           road_on,
   input  logic [NUM_LANES-1:0]           car_on,
   output logic [NUM_LANES-1:0]           path,
   output logic                           path_valid,
   output logic                           obs_valid,
   input  logic                           obs_ready,
   output logic [$clog2(NUM_LANES)-1:0]   obs_lane,
   output logic [SPEED_W-1:0]             obs_speed,
   output logic [NUM_LANES*SPEED_W-1:0]   speed_data,
   output logic                           spawn_fail
`ifdef LANE_SPAWNER_STATS_EN
   ,
   output logic [15:0]                    spawn_cnt,
   output logic [15:0]                    fail_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_LANES);
   localparam int CD_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam int SMAX  = 2**SPEED_W - 1;

   localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(SPAWN_GAP - 1);
   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);

   logic [LFSR_W-1:0] lfsr;
   logic [IDX_W-1:0]  rnd_a, rnd_b;

   galois_lfsr #(
      .LFSR_W    (LFSR_W),
      .LFSR_TAPS (LFSR_TAPS),
      .SEED      (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .step2 (|direction),
      .state (lfsr)
   );

   assign rnd_a = IDX_W'(lfsr[7:0] % 8'(NUM_LANES));
   assign rnd_b = IDX_W'(lfsr[LFSR_W-1 -: 8] % 8'(NUM_LANES));

   logic [SPEED_W-1:0] base_tbl [NUM_LANES];
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_base
      assign base_tbl[i] = SPEED_W'(lane_base_speed(i, NUM_LANES, SMAX));
   end

   spawn_state_t     state, state_nx;
   logic [CD_W-1:0]  cooldown, cooldown_nx;
   logic [IDX_W-1:0] idx, idx_nx, tries, tries_nx;
   logic             offer_load, accept, fail_now, road_hit;

   always_comb begin
      state_nx    = state;
      cooldown_nx = cooldown;
      idx_nx      = idx;
      tries_nx    = tries;
      offer_load  = 1'b0;
      accept      = 1'b0;
      fail_now    = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               if (cooldown == '0) begin
                  state_nx = SCAN;
                  idx_nx   = rnd_a;
                  tries_nx = '0;
               end else begin
                  cooldown_nx = cooldown - CD_W'(1);
               end
            end
         end
         SCAN: begin
            if (!enable) begin
               state_nx    = IDLE;
               cooldown_nx = CD_RELOAD;
            end else if (!car_on[idx]) begin
               state_nx   = OFFER;
               offer_load = 1'b1;
            end else if (tries == LAST_LANE) begin
               fail_now    = 1'b1;
               state_nx    = IDLE;
               cooldown_nx = CD_RELOAD;
            end else begin
               idx_nx   = (idx == LAST_LANE) ? '0 : idx + IDX_W'(1);
               tries_nx = tries + IDX_W'(1);
            end
         end
         OFFER: begin
            // Offer is committed: car_on and enable are ignored until the consumer takes it.
            if (obs_ready) begin
               accept      = 1'b1;
               state_nx    = IDLE;
               cooldown_nx = CD_RELOAD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cooldown <= CD_RELOAD;
         idx      <= '0;
         tries    <= '0;
      end else begin
         state    <= state_nx;
         cooldown <= cooldown_nx;
         idx      <= idx_nx;
         tries    <= tries_nx;
      end
   end

   assign obs_valid = (state == OFFER);
   assign road_hit  = road_tick && !road_on[rnd_b];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obs_lane   <= '0;
         obs_speed  <= '0;
         speed_data <= '0;
         spawn_fail <= 1'b0;
         path       <= '0;
         path_valid <= 1'b0;
      end else begin
         spawn_fail <= fail_now;
         path_valid <= road_hit;
         if (road_hit) begin
            path <= {{(NUM_LANES-1){1'b0}}, 1'b1} << rnd_b;
         end
         if (offer_load) begin
            obs_lane  <= idx;
            obs_speed <= base_tbl[idx];
         end
         for (int i = 0; i < NUM_LANES; i++) begin
            if (accept && obs_lane == IDX_W'(i)) begin
               speed_data[i*SPEED_W +: SPEED_W] <= obs_speed;
            end
         end
      end
   end

`ifdef LANE_SPAWNER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spawn_cnt <= '0;
         fail_cnt  <= '0;
      end else begin
         if (accept && spawn_cnt != 16'hFFFF) begin
            spawn_cnt <= spawn_cnt + 16'd1;
         end
         if (fail_now && fail_cnt != 16'hFFFF) begin
            fail_cnt <= fail_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lane_spawner.sv
// Scoreboard bench for lane_spawner: stimulus queues expected offers/paths/fails, a negedge monitor retires them.
module tb_lane_spawner;
   import spawner_pkg::*;

   localparam int N   = 5;
   localparam int SW  = 2;
   localparam int GAP = 16;

   logic            clk = 1'b0;
   logic            rst_n, enable, road_tick, obs_ready;
   logic [3:0]      direction;
   logic [N-1:0]    road_on, car_on;
   logic [N-1:0]    path;
   logic            path_valid, obs_valid, spawn_fail;
   logic [2:0]      obs_lane;
   logic [SW-1:0]   obs_speed;
   logic [N*SW-1:0] speed_data;

   always #5 clk = ~clk;

   lane_spawner #(
      .NUM_LANES (N),
      .SPEED_W   (SW),
      .LFSR_W    (16),
      .LFSR_TAPS (16'hB400),
      .SEED      (16'h0000),
      .SPAWN_GAP (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .direction  (direction),
      .road_tick  (road_tick),
      .road_on    (road_on),
      .car_on     (car_on),
      .path       (path),
      .path_valid (path_valid),
      .obs_valid  (obs_valid),
      .obs_ready  (obs_ready),
      .obs_lane   (obs_lane),
      .obs_speed  (obs_speed),
      .speed_data (speed_data),
      .spawn_fail (spawn_fail)
   );

   typedef struct packed {
      logic [2:0]    lane;
      logic [SW-1:0] speed;
   } obs_t;

   obs_t          obs_q[$];
   logic [N-1:0]  path_q[$];
   int            fail_pend;
   int            errors = 0;
   int            checks = 0;
   logic [SW-1:0] base_exp [N] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference LFSR tracking the DUT from reset, including the double step on steering.
   logic [15:0] m_lfsr;
   function automatic logic [15:0] ref_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'h0001;
      else        m_lfsr <= (direction != 4'd0) ? ref_step(ref_step(m_lfsr)) : ref_step(m_lfsr);
   end

   always @(negedge clk) begin
      obs_t         e;
      logic [N-1:0] p;
      if (rst_n === 1'b1) begin
         if (obs_valid && obs_ready) begin
            check("obs_expected", 32'(obs_q.size() != 0), 1);
            if (obs_q.size() != 0) begin
               e = obs_q.pop_front();
               check("obs_lane", 32'(obs_lane), 32'(e.lane));
               check("obs_speed", 32'(obs_speed), 32'(e.speed));
            end
         end
         if (path_valid) begin
            check("path_expected", 32'(path_q.size() != 0), 1);
            if (path_q.size() != 0) begin
               p = path_q.pop_front();
               check("path_value", 32'(path), 32'(p));
            end
         end
         if (spawn_fail) begin
            check("fail_expected", 32'(fail_pend > 0), 1);
            if (fail_pend > 0) fail_pend--;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int           cnt, scan_cycles;
      logic         seen;
      logic [2:0]   la;
      logic [N-1:0] exp_path;
      logic [N*SW-1:0] exp_sd;
      logic [15:0]  v0, vexp;

      rst_n = 1'b0; enable = 1'b0; road_tick = 1'b0; obs_ready = 1'b0;
      direction = 4'd0; road_on = '0; car_on = '0;
      exp_path = '0; exp_sd = '0; fail_pend = 0;

      repeat (2) @(negedge clk);
      check("rst_lfsr", 32'(dut.u_lfsr.state), 32'h0001);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      check("rst_cooldown", 32'(dut.cooldown), GAP - 1);
      check("rst_path", 32'(path), 0);
      check("rst_speed_data", 32'(speed_data), 0);
      check("rst_pulses", 32'({path_valid, obs_valid, spawn_fail}), 0);
      check("rst_obs", 32'({obs_lane, obs_speed}), 0);

      // First spawn with all lanes free: lane comes from rnd_a just before SCAN entry.
      @(posedge clk); #1;
      rst_n = 1'b1; enable = 1'b1; obs_ready = 1'b1; car_on = '0;
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 4*GAP) begin
         if (cnt == GAP - 1) begin
            la = 3'(m_lfsr[7:0] % 8'd5);
            obs_q.push_back('{lane: la, speed: base_exp[la]});
            exp_sd[la*SW +: SW] = base_exp[la];
         end
         @(posedge clk); cnt++;
         @(negedge clk); seen = obs_valid;
      end
      check("first_valid_latency", 32'(cnt), GAP + 1);

      // Only lane 2 free: whatever the start lane, the scan lands on 2.
      @(posedge clk); #1;
      car_on = 5'b11011;
      obs_q.push_back('{lane: 3'd2, speed: 2'd2});
      exp_sd[2*SW +: SW] = 2'd2;
      cnt = 0;
      while (obs_q.size() != 0 && cnt < 4*GAP) begin
         @(negedge clk); cnt++;
      end
      check("t2_offer_seen", 32'(obs_q.size()), 0);
      @(posedge clk); #1;
      check("t2_speed_data", 32'(speed_data), 32'(exp_sd));
      @(negedge clk);
      check("t2_valid_drop", 32'(obs_valid), 0);

      // All lanes busy: one fail after a full 5-lane scan.
      car_on = 5'b11111;
      fail_pend = 1;
      cnt = 0; scan_cycles = 0; seen = 1'b0;
      while (!seen && cnt < 4*GAP) begin
         @(negedge clk); cnt++;
         if (dut.state == SCAN) scan_cycles++;
         seen = spawn_fail;
      end
      check("t3_fail_seen", 32'(seen), 1);
      check("t3_scan_cycles", 32'(scan_cycles), 5);
      check("t3_cooldown_reload", 32'(dut.cooldown), GAP - 1);
      check("t3_no_valid", 32'(obs_valid), 0);
      @(negedge clk);
      check("t3_fail_one_cycle", 32'(spawn_fail), 0);

      // Offer held under backpressure while car_on and enable wiggle.
      @(posedge clk); #1;
      car_on = 5'b10111; obs_ready = 1'b0;
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 4*GAP) begin
         @(negedge clk); cnt++; seen = obs_valid;
      end
      check("t4_offer_seen", 32'(seen), 1);
      obs_q.push_back('{lane: 3'd3, speed: 2'd3});
      exp_sd[3*SW +: SW] = 2'd3;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         car_on = 5'(k*7 + 3);
         enable = k[0];
         @(negedge clk);
         check("t4_hold_valid", 32'(obs_valid), 1);
         check("t4_hold_lane", 32'(obs_lane), 3);
         check("t4_hold_speed", 32'(obs_speed), 3);
      end
      @(posedge clk); #1;
      obs_ready = 1'b1; enable = 1'b1;
      @(posedge clk); #1;
      obs_ready = 1'b0;
      @(negedge clk);
      check("t4_valid_drop", 32'(obs_valid), 0);
      check("t4_speed_data", 32'(speed_data), 32'(exp_sd));

      // Road path: blocked tick, free tick, tick with every other lane occupied.
      @(posedge clk); #1;
      enable = 1'b0; road_on = '1; road_tick = 1'b1;
      @(posedge clk); #1;
      road_tick = 1'b0;
      @(negedge clk);
      check("t5_blocked_path", 32'(path), 32'(exp_path));
      check("t5_blocked_pulse", 32'(path_valid), 0);

      @(posedge clk); #1;
      road_on = '0;
      la = 3'(m_lfsr[15:8] % 8'd5);
      exp_path = 5'd1 << la;
      path_q.push_back(exp_path);
      road_tick = 1'b1;
      @(posedge clk); #1;
      road_tick = 1'b0;
      @(negedge clk);
      check("t5_path", 32'(path), 32'(exp_path));
      @(negedge clk);
      check("t5_pulse_once", 32'(path_valid), 0);
      check("t5_path_hold", 32'(path), 32'(exp_path));

      @(posedge clk); #1;
      la = 3'(m_lfsr[15:8] % 8'd5);
      exp_path = 5'd1 << la;
      road_on = ~exp_path;
      path_q.push_back(exp_path);
      road_tick = 1'b1;
      @(posedge clk); #1;
      road_tick = 1'b0;
      @(negedge clk);
      check("t5_path_crowded", 32'(path), 32'(exp_path));

      // Steering doubles the LFSR step rate.
      @(posedge clk); #1;
      check("t6_model_sync", 32'(dut.u_lfsr.state), 32'(m_lfsr));
      v0 = m_lfsr;
      direction = 4'b0010;
      repeat (4) @(posedge clk);
      #1;
      direction = 4'd0;
      vexp = v0;
      for (int s = 0; s < 8; s++) vexp = ref_step(vexp);
      check("t6_lfsr_8steps", 32'(dut.u_lfsr.state), 32'(vexp));

      // Reset in the middle of an offer clears it without a clock edge.
      road_on = '0; car_on = '0; obs_ready = 1'b0; enable = 1'b1;
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 4*GAP) begin
         @(negedge clk); cnt++; seen = obs_valid;
      end
      check("t7_offer_seen", 32'(seen), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t7_async_drop", 32'(obs_valid), 0);
      check("t7_async_lfsr", 32'(dut.u_lfsr.state), 32'h0001);
      #10;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      check("end_obs_q", 32'(obs_q.size()), 0);
      check("end_path_q", 32'(path_q.size()), 0);
      check("end_fail_pend", 32'(fail_pend), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
